// File: rtl/pixel_store_pkg.sv
// Shared types and helpers for the pixel_store framebuffer block.
// Coordinate, address and colour widths, the FSM state type and the queued-plot record.
package pixel_store_pkg;

    localparam int unsigned COORD_X_W = 8;
    localparam int unsigned COORD_Y_W = 7;
    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned COLOUR_W  = 3;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } plot_entry_t;

    // y*160 + x as two shifts and adds, avoiding a multiplier.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [COORD_X_W-1:0] x,
                                                     input logic [COORD_Y_W-1:0] y);
        return ADDR_W'({y, 7'b0}) + ADDR_W'({y, 5'b0}) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/pixel_store_fifo.sv
// pixel_fifo: small synchronous FIFO holding queued plots in front of the framebuffer port.
// With PIXEL_STORE_FWD_EN defined it also exposes every slot in age order (oldest first).
module pixel_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
`ifdef PIXEL_STORE_FWD_EN
    ,
    output logic [DEPTH*DATA_W-1:0] age_data,
    output logic [DEPTH-1:0]        age_valid
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign dout  = mem[rd_ptr_q[AW-1:0]];

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which slots hold valid data.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q[AW-1:0]] <= din;
    end

`ifdef PIXEL_STORE_FWD_EN
    logic [AW:0] count;
    assign count = wr_ptr_q - rd_ptr_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_age
        logic [AW-1:0] slot;
        assign slot                         = rd_ptr_q[AW-1:0] + AW'(i);
        assign age_data[i*DATA_W +: DATA_W] = mem[slot];
        assign age_valid[i]                 = ((AW+1)'(i) < count);
    end
`endif

endmodule

// File: rtl/pixel_store.sv
// pixel_store: 160x120x3 framebuffer fed by a queued plot stream, with a priority read-back port.
// Optional macro PIXEL_STORE_FWD_EN: reads see the youngest still-queued plot to the same pixel.
module pixel_store
    import pixel_store_pkg::*;
#(
    parameter int unsigned         WIDTH      = 160,
    parameter int unsigned         HEIGHT     = 120,
    parameter int unsigned         FIFO_DEPTH = 4,
    parameter logic [COLOUR_W-1:0] BG_COLOUR  = 3'b000,
    parameter logic [COLOUR_W-1:0] OOB_COLOUR = 3'b111
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       plot,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    input  logic       rd_req,
    input  logic [7:0] rd_x,
    input  logic [6:0] rd_y,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [2:0] rd_colour,
    input  logic       clear_req,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned          NPIX      = WIDTH * HEIGHT;
    localparam int unsigned          ENTRY_W   = $bits(plot_entry_t);
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [COORD_X_W:0]   X_LIM     = (COORD_X_W+1)'(WIDTH);
    localparam logic [COORD_Y_W:0]   Y_LIM     = (COORD_Y_W+1)'(HEIGHT);

    function automatic logic [ADDR_W-1:0] addr_of(input logic [COORD_X_W-1:0] x,
                                                  input logic [COORD_Y_W-1:0] y);
        if (WIDTH == 160) return pixel_addr(x, y);
        return ADDR_W'(int'(y) * WIDTH + int'(x));
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clear_addr_q, clear_addr_d;
    logic                overflow_q, overflow_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_oob_q, rd_oob_d;

    logic                rd_accept, rd_in_range, plot_in_range;
    logic [ADDR_W-1:0]   rd_addr, plot_addr;

    logic                fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    plot_entry_t         push_entry, head;

    logic                ram_we, ram_re;
    logic [ADDR_W-1:0]   ram_addr;
    logic [COLOUR_W-1:0] ram_wdata, ram_rdata;
    logic [COLOUR_W-1:0] fb_mem [NPIX];

    assign rd_in_range   = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
    assign plot_in_range = ({1'b0, x_in} < X_LIM) && ({1'b0, y_in} < Y_LIM);
    assign rd_addr       = addr_of(rd_x, rd_y);
    assign plot_addr     = addr_of(x_in, y_in);
    assign rd_accept     = rd_req && (state_q == S_RUN);
    assign push_entry    = '{addr: plot_addr, colour: colour_in};

`ifdef PIXEL_STORE_FWD_EN
    logic [FIFO_DEPTH*ENTRY_W-1:0] fifo_age_data;
    logic [FIFO_DEPTH-1:0]         fifo_age_valid;
`endif

    pixel_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .din       (push_entry),
        .dout      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
`ifdef PIXEL_STORE_FWD_EN
        ,
        .age_data  (fifo_age_data),
        .age_valid (fifo_age_valid)
`endif
    );

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        rd_valid_d   = 1'b0;
        rd_oob_d     = 1'b0;
        fifo_flush   = 1'b0;
        fifo_pop     = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_addr     = clear_addr_q;
        ram_wdata    = BG_COLOUR;

        unique case (state_q)
            S_CLEAR: begin
                ram_we = 1'b1;
                if (clear_addr_q == LAST_ADDR) begin
                    state_d      = S_RUN;
                    clear_addr_d = '0;
                end else begin
                    clear_addr_d = clear_addr_q + ADDR_W'(1);
                end
            end
            S_RUN: begin
                if (clear_req) begin
                    state_d      = S_CLEAR;
                    clear_addr_d = '0;
                    fifo_flush   = 1'b1;
                end
                // A read owns the single port this cycle; the queue drains only when reads pause.
                if (rd_accept) begin
                    rd_valid_d = 1'b1;
                    if (rd_in_range) begin
                        ram_re   = 1'b1;
                        ram_addr = rd_addr;
                    end else begin
                        rd_oob_d = 1'b1;
                    end
                end else if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = head.addr;
                    ram_wdata = head.colour;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // A full queue still accepts a plot when the head leaves in the same cycle; a flush discards it.
    always_comb begin
        fifo_push  = plot && plot_in_range && !fifo_flush && (!fifo_full || fifo_pop);
        overflow_d = overflow_q;
        if (plot && plot_in_range && !fifo_flush && fifo_full && !fifo_pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_CLEAR;
            clear_addr_q <= '0;
            overflow_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_oob_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            overflow_q   <= overflow_d;
            rd_valid_q   <= rd_valid_d;
            rd_oob_q     <= rd_oob_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) fb_mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= fb_mem[ram_addr];
    end

`ifdef PIXEL_STORE_FWD_EN
    logic                fwd_hit_q, fwd_hit_d;
    logic [COLOUR_W-1:0] fwd_colour_q, fwd_colour_d;
    plot_entry_t         fwd_entry;

    // Oldest-to-youngest scan: the last match wins, so the youngest queued write is returned.
    always_comb begin
        fwd_hit_d    = 1'b0;
        fwd_colour_d = '0;
        fwd_entry    = '0;
        if (rd_accept && rd_in_range) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fwd_entry = fifo_age_data[i*ENTRY_W +: ENTRY_W];
                if (fifo_age_valid[i] && (fwd_entry.addr == rd_addr)) begin
                    fwd_hit_d    = 1'b1;
                    fwd_colour_d = fwd_entry.colour;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_hit_q    <= 1'b0;
            fwd_colour_q <= '0;
        end else begin
            fwd_hit_q    <= fwd_hit_d;
            fwd_colour_q <= fwd_colour_d;
        end
    end

    assign rd_colour = !rd_valid_q ? '0 :
                       rd_oob_q    ? OOB_COLOUR :
                       fwd_hit_q   ? fwd_colour_q : ram_rdata;
`else
    assign rd_colour = !rd_valid_q ? '0 :
                       rd_oob_q    ? OOB_COLOUR : ram_rdata;
`endif

    assign rd_valid = rd_valid_q;
    assign rd_ready = (state_q == S_RUN);
    assign busy     = (state_q == S_CLEAR);
    assign overflow = overflow_q;

endmodule
